// File: rtl/keypad_code_entry_pkg.sv
// Shared safe definitions: keypad key codes and code-entry state encoding.
package keypad_code_entry_pkg;

    localparam logic [4:0] KEY_CLEAR     = 5'h10;
    localparam logic [4:0] KEY_ENTER     = 5'h11;
    localparam logic [4:0] KEY_BACKSPACE = 5'h12;

    typedef enum logic [1:0] {
        StIdle,
        StEntry,
        StPresent
    } entry_state_e;

    function automatic logic is_digit(input logic [4:0] key);
        return key[4] == 1'b0;
    endfunction

    // Digits plus CLEAR/ENTER/BACKSPACE; everything above is reserved.
    function automatic logic is_known(input logic [4:0] key);
        return key <= KEY_BACKSPACE;
    endfunction

endpackage

// File: rtl/entry_timer.sv
// Inter-key idle timer: pulses expired once TIMEOUT_CYCLES enabled cycles pass without a restart.
module entry_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic enable,
    output logic expired
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (restart || !enable) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A key arriving on the expiry cycle wins over the timeout.
    assign expired = enable && !restart && (cnt == LAST);

endmodule

// File: rtl/keypad_code_entry.sv
// Keypad code entry: collects hex digits, presents a complete code until acknowledged.
module keypad_code_entry
    import keypad_code_entry_pkg::*;
#(
    parameter int unsigned DIGITS         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         key_valid,
    input  logic [4:0]                   key_code,
    input  logic                         lock_in,
    input  logic                         code_ack,
    output logic [4*DIGITS-1:0]          entered_code,
    output logic                         code_valid,
    output logic [$clog2(DIGITS+1)-1:0]  digit_count,
    output logic                         entry_error
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] FULL = CW'(DIGITS);

    entry_state_e  state;
    logic [BW-1:0] buffer;
    logic [CW-1:0] count;
    logic          key_taken;
    logic          timer_expired;

    assign key_taken = (state != StPresent) && key_valid && !lock_in && is_known(key_code);

    entry_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_entry_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (key_taken),
        .enable  (state == StEntry),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= StIdle;
            buffer       <= '0;
            count        <= '0;
            entered_code <= '0;
            code_valid   <= 1'b0;
            digit_count  <= '0;
            entry_error  <= 1'b0;
        end else begin
            entry_error <= 1'b0;
            unique case (state)
                StPresent: begin
                    if (code_ack) begin
                        state        <= StIdle;
                        buffer       <= '0;
                        count        <= '0;
                        entered_code <= '0;
                        code_valid   <= 1'b0;
                        digit_count  <= '0;
                    end
                end
                default: begin
                    if (lock_in) begin
                        state       <= StIdle;
                        buffer      <= '0;
                        count       <= '0;
                        digit_count <= '0;
                    end else if (key_taken && is_digit(key_code)) begin
                        if (count == FULL) begin
                            entry_error <= 1'b1;
                        end else begin
                            state       <= StEntry;
                            buffer      <= {buffer[BW-5:0], key_code[3:0]};
                            count       <= count + 1'b1;
                            digit_count <= count + 1'b1;
                        end
                    end else if (key_taken && key_code == KEY_ENTER && count == FULL) begin
                        state        <= StPresent;
                        entered_code <= buffer;
                        code_valid   <= 1'b1;
                        digit_count  <= FULL;
                    end else if (key_taken && key_code == KEY_BACKSPACE) begin
                        if (count != '0) begin
                            buffer      <= {4'h0, buffer[BW-1:4]};
                            count       <= count - 1'b1;
                            digit_count <= count - 1'b1;
                            if (count == CW'(1)) begin
                                state <= StIdle;
                            end
                        end
                    end else if (key_taken || timer_expired) begin
                        // CLEAR, short ENTER or timeout; only CLEAR is silent.
                        entry_error <= !(key_taken && key_code == KEY_CLEAR);
                        state       <= StIdle;
                        buffer      <= '0;
                        count       <= '0;
                        digit_count <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_code_entry.sv
// Randomized and directed bench for keypad_code_entry against a queue-based reference model.
module tb_keypad_code_entry;

    localparam int unsigned DIGITS  = 8;
    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_valid = 1'b0;
    logic [4:0]  key_code = '0;
    logic        lock_in = 1'b0;
    logic        code_ack = 1'b0;
    logic [31:0] entered_code;
    logic        code_valid;
    logic [3:0]  digit_count;
    logic        entry_error;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: buffered digits in entry order, present flag, idle edge count.
    int q[$];
    bit present;
    int idle;
    bit exp_err;

    keypad_code_entry #(
        .DIGITS         (DIGITS),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .lock_in      (lock_in),
        .code_ack     (code_ack),
        .entered_code (entered_code),
        .code_valid   (code_valid),
        .digit_count  (digit_count),
        .entry_error  (entry_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] packed_code();
        logic [31:0] v = '0;
        foreach (q[i]) v = (v << 4) | 32'(q[i]);
        return v;
    endfunction

    function automatic void model_reset();
        q.delete();
        present = 1'b0;
        idle    = 0;
        exp_err = 1'b0;
    endfunction

    function automatic void model_step(input bit kv, input int kc, input bit lk, input bit ack);
        exp_err = 1'b0;
        if (present) begin
            if (ack) begin
                present = 1'b0;
                q.delete();
            end
        end else if (lk) begin
            q.delete();
            idle = 0;
        end else if (kv && kc <= 'h12) begin
            idle = 0;
            if (kc < 16) begin
                if (q.size() == DIGITS) exp_err = 1'b1;
                else q.push_back(kc);
            end else if (kc == 'h10) begin
                q.delete();
            end else if (kc == 'h11) begin
                if (q.size() == DIGITS) present = 1'b1;
                else begin
                    exp_err = 1'b1;
                    q.delete();
                end
            end else if (q.size() > 0) begin
                void'(q.pop_back());
            end
        end else if (q.size() > 0) begin
            idle++;
            if (idle == TIMEOUT) begin
                exp_err = 1'b1;
                q.delete();
                idle = 0;
            end
        end
    endfunction

    task automatic compare_all();
        check("code_valid", 32'(code_valid), 32'(present));
        check("entered_code", entered_code, present ? packed_code() : 32'h0);
        check("digit_count", 32'(digit_count), present ? 32'(DIGITS) : 32'(q.size()));
        check("entry_error", 32'(entry_error), 32'(exp_err));
    endtask

    task automatic cycle(input bit kv, input int kc, input bit lk, input bit ack);
        @(negedge clk);
        key_valid = kv;
        key_code  = 5'(kc);
        lock_in   = lk;
        code_ack  = ack;
        model_step(kv, kc, lk, ack);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic press(input int kc);
        cycle(1'b1, kc, 1'b0, 1'b0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        int seq1[8] = '{1, 2, 3, 4, 5, 6, 7, 8};
        int seq3[9] = '{'hA, 'hA, 'hB, 'hB, 'hC, 'hC, 'hD, 'hD, 'hE};
        int seq4[10] = '{1, 1, 1, 9, 'h12, 2, 2, 2, 2, 2};
        int seq6[8] = '{8, 7, 6, 5, 4, 3, 2, 1};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst = 1'b1;

        // Plain 8-digit code, held until ack.
        foreach (seq1[i]) press(seq1[i]);
        press('h11);
        check("req31_code", entered_code, 32'h1234_5678);
        idle_cycles(5);
        check("req31_hold", entered_code, 32'h1234_5678);
        press(3);
        cycle(1'b0, 0, 1'b0, 1'b1);
        check("req31_ack", entered_code, 32'h0);

        // Short ENTER.
        press('hD); press('hE); press('hA); press('hD);
        press('h11);
        check("req32_err", 32'(entry_error), 32'h1);
        idle_cycles(2);

        // Overflow digit then ENTER.
        foreach (seq3[i]) press(seq3[i]);
        check("req33_err", 32'(entry_error), 32'h1);
        press('h11);
        check("req33_code", entered_code, 32'hAABB_CCDD);
        cycle(1'b1, 5, 1'b0, 1'b1);

        // Backspace mid-entry and in idle.
        press('h12);
        check("req34_idle_bs", 32'(digit_count), 32'h0);
        foreach (seq4[i]) press(seq4[i]);
        press('h11);
        check("req34_code", entered_code, 32'h1112_2222);
        cycle(1'b0, 0, 1'b0, 1'b1);

        // Timeout, then lockout during entry.
        press(8);
        idle_cycles(TIMEOUT);
        check("req35_timeout", 32'(entry_error), 32'h1);
        press(3); press(4);
        cycle(1'b1, 5, 1'b1, 1'b0);
        cycle(1'b1, 6, 1'b1, 1'b0);
        check("req35_lock", 32'(digit_count), 32'h0);
        press('h1F);
        idle_cycles(2);

        // Asynchronous reset while presenting.
        foreach (seq6[i]) press(seq6[i]);
        press('h11);
        check("req36_pre", entered_code, 32'h8765_4321);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("req36_valid", 32'(code_valid), 32'h0);
        check("req36_code", entered_code, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        press(7);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            int r;
            int kc;
            r = int'($urandom_range(0, 99));
            if (r < 70)      kc = int'($urandom_range(0, 15));
            else if (r < 78) kc = 'h11;
            else if (r < 85) kc = 'h12;
            else if (r < 89) kc = 'h10;
            else             kc = int'($urandom_range(19, 31));
            cycle($urandom_range(0, 3) != 0, kc, $urandom_range(0, 59) == 0,
                  $urandom_range(0, 5) == 0);
            if ($urandom_range(0, 199) == 0) idle_cycles(TIMEOUT + 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
